// File: rtl/step_seq_pkg.sv
// Shared types and helpers for the STEP/DIR pulse sequencer.
package step_seq_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DIR_SETUP = 2'd1,
      STEP_HI   = 2'd2,
      STEP_LO   = 2'd3
   } state_e;

   // Period actually used for a move: never shorter than the high phase plus
   // one low cycle, so every pulse has a real falling edge before the next one.
   function automatic logic [63:0] eff_period(input logic [63:0] period,
                                              input logic [63:0] hi_cyc);
      return (period > hi_cyc) ? period : hi_cyc + 64'd1;
   endfunction

endpackage

// File: rtl/step_pulse_sequencer_if.sv
// Move-command handshake between the register file and the sequencer.
interface step_pulse_sequencer_if #(
   parameter int STEPS_W = 16,
   parameter int PER_W   = 24
);
   logic               cmd_valid;
   logic               cmd_ready;
   logic               cmd_dir;
   logic [STEPS_W-1:0] cmd_steps;
   logic [PER_W-1:0]   cmd_period;

   modport master (output cmd_valid, cmd_dir, cmd_steps, cmd_period,
                   input  cmd_ready);
   modport slave  (input  cmd_valid, cmd_dir, cmd_steps, cmd_period,
                   output cmd_ready);
endinterface

// File: rtl/step_cyc_timer.sv
// Loadable down-counter shared by every timed phase of the sequencer.
// A phase lasting N cycles loads N-1; expired_o marks the phase's last cycle.
module step_cyc_timer #(
   parameter int PER_W = 24
) (
   input  logic             ACLK,
   input  logic             ARESETN,
   input  logic             load_i,
   input  logic [PER_W-1:0] load_val_i,
   output logic             expired_o
);

   localparam logic [PER_W-1:0] ONE = PER_W'(1);

   logic [PER_W-1:0] cnt_d, cnt_q;

   // Next count: reload on request, otherwise count down and hold at zero.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - ONE;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge ACLK) begin
      // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
      if (!ARESETN) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/step_pulse_sequencer.sv
// STEP/DIR pin sequencer: turns move commands into evenly spaced STEP pulses,
// with DIR setup before a reversal, fixed high width, no runt pulses on abort
// and a wrapping signed position count.
module step_pulse_sequencer
   import step_seq_pkg::*;
#(
   parameter int STEPS_W       = 16,
   parameter int PER_W         = 24,
   parameter int POS_W         = 32,
   parameter int DIR_SETUP_CYC = 10,
   parameter int PULSE_HI_CYC  = 100
) (
   input  logic                 ACLK,
   input  logic                 ARESETN,
   input  logic                 enable,
   step_pulse_sequencer_if.slave cmd,
   input  logic                 abort,
   output logic                 step_out,
   output logic                 dir_out,
   output logic                 busy,
   output logic                 done_pulse,
   output logic                 aborted,
   output logic [STEPS_W-1:0]   steps_left,
   output logic [POS_W-1:0]     position
);

   localparam logic [PER_W-1:0]   DIR_LOAD = PER_W'(DIR_SETUP_CYC - 1);
   localparam logic [PER_W-1:0]   HI_LOAD  = PER_W'(PULSE_HI_CYC - 1);
   localparam logic [PER_W-1:0]   LO_SUB   = PER_W'(PULSE_HI_CYC + 1);
   localparam logic [STEPS_W-1:0] STEP_ONE = STEPS_W'(1);
   localparam logic [POS_W-1:0]   POS_ONE  = POS_W'(1);

   state_e             state_d, state_q;
   logic [STEPS_W-1:0] steps_left_d, steps_left_q;
   logic [PER_W-1:0]   per_d, per_q;
   logic [POS_W-1:0]   pos_d, pos_q;
   logic               dir_d, dir_q;
   logic               step_d, step_q;
   logic               done_d, done_q;
   logic               aborted_d, aborted_q;
   logic               abort_pend_d, abort_pend_q;

   logic               tmr_load;
   logic [PER_W-1:0]   tmr_val;
   logic               tmr_exp;

   logic               stop_req;
   logic               accept;
   logic               go_hi;
   logic               go_idle;
   logic [STEPS_W-1:0] hi_left;
   logic [PER_W-1:0]   eff_per;

   step_cyc_timer #(.PER_W(PER_W)) u_timer (
      .ACLK       (ACLK),
      .ARESETN    (ARESETN),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .expired_o  (tmr_exp)
   );

   assign stop_req      = abort | ~enable;
   assign cmd.cmd_ready = ARESETN & (state_q == IDLE) & enable & ~abort;
   assign accept        = cmd.cmd_valid & cmd.cmd_ready;
   assign eff_per       = PER_W'(eff_period(64'(cmd.cmd_period), 64'(PULSE_HI_CYC)));

   // Next-state and output decode; entering STEP_HI and returning to IDLE are
   // shared tails so every path issues a pulse or finishes a move identically.
   always_comb begin
      state_d      = state_q;
      steps_left_d = steps_left_q;
      per_d        = per_q;
      pos_d        = pos_q;
      dir_d        = dir_q;
      step_d       = step_q;
      done_d       = 1'b0;
      aborted_d    = aborted_q;
      abort_pend_d = abort_pend_q;
      tmr_load     = 1'b0;
      tmr_val      = '0;
      go_hi        = 1'b0;
      go_idle      = 1'b0;
      hi_left      = steps_left_q;

      case (state_q)
         IDLE: begin
            abort_pend_d = 1'b0;
            if (accept) begin
               steps_left_d = cmd.cmd_steps;
               per_d        = eff_per;
               aborted_d    = 1'b0;
               dir_d        = cmd.cmd_dir;
               if (cmd.cmd_steps == '0) begin
                  done_d = 1'b1;
               end else if (cmd.cmd_dir != dir_q) begin
                  state_d  = DIR_SETUP;
                  tmr_load = 1'b1;
                  tmr_val  = DIR_LOAD;
               end else begin
                  go_hi   = 1'b1;
                  hi_left = cmd.cmd_steps;
               end
            end
         end

         DIR_SETUP: begin
            if (stop_req) begin
               go_idle   = 1'b1;
               aborted_d = 1'b1;
            end else if (tmr_exp) begin
               go_hi = 1'b1;
            end
         end

         STEP_HI: begin
            // An abort seen during the high phase is remembered and honoured
            // only once the full high width has been driven.
            if (stop_req) begin
               abort_pend_d = 1'b1;
            end
            if (tmr_exp) begin
               if (stop_req || abort_pend_q) begin
                  go_idle   = 1'b1;
                  aborted_d = 1'b1;
               end else begin
                  state_d  = STEP_LO;
                  step_d   = 1'b0;
                  tmr_load = 1'b1;
                  tmr_val  = per_q - LO_SUB;
               end
            end
         end

         STEP_LO: begin
            if (stop_req) begin
               go_idle   = 1'b1;
               aborted_d = 1'b1;
            end else if (tmr_exp) begin
               if (steps_left_q != '0) begin
                  go_hi = 1'b1;
               end else begin
                  go_idle = 1'b1;
               end
            end
         end

         default: begin
            go_idle = 1'b1;
         end
      endcase

      // Rising edge, step count and position change together.
      if (go_hi) begin
         state_d      = STEP_HI;
         step_d       = 1'b1;
         steps_left_d = hi_left - STEP_ONE;
         pos_d        = dir_q ? (pos_q + POS_ONE) : (pos_q - POS_ONE);
         tmr_load     = 1'b1;
         tmr_val      = HI_LOAD;
      end

      if (go_idle) begin
         state_d      = IDLE;
         step_d       = 1'b0;
         done_d       = 1'b1;
         abort_pend_d = 1'b0;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state_q      <= IDLE;
         steps_left_q <= '0;
         per_q        <= '0;
         pos_q        <= '0;
         dir_q        <= 1'b0;
         step_q       <= 1'b0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
         abort_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         steps_left_q <= steps_left_d;
         per_q        <= per_d;
         pos_q        <= pos_d;
         dir_q        <= dir_d;
         step_q       <= step_d;
         done_q       <= done_d;
         aborted_q    <= aborted_d;
         abort_pend_q <= abort_pend_d;
      end
   end

   assign step_out   = step_q;
   assign dir_out    = dir_q;
   assign busy       = (state_q != IDLE);
   assign done_pulse = done_q;
   assign aborted    = aborted_q;
   assign steps_left = steps_left_q;
   assign position   = pos_q;

endmodule

// File: tb/tb_step_pulse_sequencer.sv
// Self-checking bench: a schedule-based model predicts every output from the
// accept cycle, the effective period and any abort cycle; directed moves pin
// the model with literal timings, then a randomized run follows.
module tb_step_pulse_sequencer;

   localparam int STEPS_W = 16;
   localparam int PER_W   = 24;
   localparam int POS_W   = 32;
   localparam int DSC     = 4;
   localparam int PHI     = 2;

   logic               ACLK = 1'b0;
   logic               ARESETN;
   logic               enable;
   logic               abort;
   logic               step_out, dir_out, busy, done_pulse, aborted;
   logic [STEPS_W-1:0] steps_left;
   logic [POS_W-1:0]   position;

   step_pulse_sequencer_if #(.STEPS_W(STEPS_W), .PER_W(PER_W)) cmd_if ();

   step_pulse_sequencer #(
      .STEPS_W(STEPS_W), .PER_W(PER_W), .POS_W(POS_W),
      .DIR_SETUP_CYC(DSC), .PULSE_HI_CYC(PHI)
   ) dut (
      .ACLK       (ACLK),
      .ARESETN    (ARESETN),
      .enable     (enable),
      .cmd        (cmd_if),
      .abort      (abort),
      .step_out   (step_out),
      .dir_out    (dir_out),
      .busy       (busy),
      .done_pulse (done_pulse),
      .aborted    (aborted),
      .steps_left (steps_left),
      .position   (position)
   );

   always #5 ACLK = ~ACLK;

   int cyc = 0;
   always @(posedge ACLK) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   // One move at a time: rise k happens at m_start + k*m_eff for k < m_issued,
   // the first IDLE cycle (done_pulse) is m_end. Before/at the accept cycle the
   // outputs hold whatever the previous move left behind (m_p*).
   bit              m_valid, m_dir, m_ab, m_pdir, m_pab, rst_prev_low;
   int              m_c, m_start, m_n, m_eff, m_issued, m_end, m_pend;
   logic [15:0]     m_pleft;
   logic [31:0]     m_base;

   function automatic void model_reset();
      m_valid = 1'b0; m_pdir = 1'b0; m_pab = 1'b0; m_pleft = '0;
      m_base  = '0;   m_pend = -1;   m_ab = 1'b0;
   endfunction

   function automatic bit model_idle(input int t);
      return !m_valid || t <= m_c || t >= m_end;
   endfunction

   function automatic int rises(input int t);
      int r;
      if (t < m_start) return 0;
      r = (t - m_start) / m_eff + 1;
      return (r < m_issued) ? r : m_issued;
   endfunction

   function automatic void model_eval(input int t, output logic e_step, output logic e_dir,
                                      output logic e_busy, output logic e_done,
                                      output logic e_ab, output logic [15:0] e_left,
                                      output logic [31:0] e_pos);
      int r, k, off;
      if (!m_valid || t <= m_c) begin
         e_step = 1'b0; e_dir = m_pdir; e_busy = 1'b0; e_done = (t == m_pend);
         e_ab = m_pab;  e_left = m_pleft; e_pos = m_base;
      end else begin
         r      = rises(t);
         e_pos  = m_dir ? m_base + 32'(r) : m_base - 32'(r);
         e_left = 16'(m_n - r);
         e_dir  = m_dir;
         e_busy = (t < m_end);
         e_done = (t == m_end);
         e_ab   = (t >= m_end) && m_ab;
         e_step = 1'b0;
         if (t >= m_start) begin
            k = (t - m_start) / m_eff;
            off = (t - m_start) % m_eff;
            e_step = (k < m_issued) && (off < PHI);
         end
      end
   endfunction

   function automatic void model_update(input int t, input bit v, input bit d, input int s,
                                        input int p, input bit ab, input bit en, input bit rn);
      logic e_step, e_dir, e_busy, e_done, e_ab;
      logic [15:0] e_left;
      logic [31:0] e_pos;
      int k, off;
      if (rst_prev_low) model_reset();
      rst_prev_low = !rn;
      if (rn && m_valid && t > m_c && t < m_end && !m_ab && (ab || !en)) begin
         if (t < m_start) begin
            m_issued = 0; m_end = t + 1;
         end else begin
            k = (t - m_start) / m_eff;
            off = (t - m_start) % m_eff;
            m_issued = k + 1;
            m_end = (off < PHI) ? m_start + k * m_eff + PHI : t + 1;
         end
         m_ab = 1'b1;
      end
      if (rn && v && en && !ab && model_idle(t)) begin
         model_eval(t, e_step, e_dir, e_busy, e_done, e_ab, e_left, e_pos);
         m_pdir = e_dir; m_pab = e_ab; m_pleft = e_left; m_base = e_pos;
         m_pend = e_done ? t : -1;
         m_valid = 1'b1; m_c = t; m_n = s; m_dir = d; m_ab = 1'b0;
         m_eff = (p > PHI + 1) ? p : PHI + 1;
         m_start = t + 1 + ((d != e_dir) ? DSC : 0);
         m_issued = s;
         m_end = (s == 0) ? t + 1 : m_start + s * m_eff;
      end
   endfunction

   // ---------------- compare process ----------------
   int rise_q[$];
   int done_q[$];
   int hi_cnt = 0;
   bit busy_seen = 1'b0;
   logic step_prev = 1'b0;

   always @(negedge ACLK) begin
      logic e_step, e_dir, e_busy, e_done, e_ab;
      logic [15:0] e_left;
      logic [31:0] e_pos;
      if (chk_en) begin
         model_eval(cyc, e_step, e_dir, e_busy, e_done, e_ab, e_left, e_pos);
         check("cmd_ready", 64'(cmd_if.cmd_ready),
               64'(ARESETN && enable && !abort && model_idle(cyc)));
         check("step_out",   64'(step_out),   64'(e_step));
         check("dir_out",    64'(dir_out),    64'(e_dir));
         check("busy",       64'(busy),       64'(e_busy));
         check("done_pulse", 64'(done_pulse), 64'(e_done));
         check("aborted",    64'(aborted),    64'(e_ab));
         check("steps_left", 64'(steps_left), 64'(e_left));
         check("position",   64'(position),   64'(e_pos));
         if (step_out === 1'b1 && step_prev !== 1'b1) rise_q.push_back(cyc);
         if (step_out === 1'b1) hi_cnt++;
         if (done_pulse === 1'b1) done_q.push_back(cyc);
         if (busy === 1'b1) busy_seen = 1'b1;
      end
      step_prev = step_out;
   end

   // ---------------- stimulus ----------------
   task automatic drive(input bit v, input bit d, input int s, input int p,
                        input bit ab, input bit en, input bit rn);
      @(posedge ACLK);
      #1;
      cmd_if.cmd_valid  = v;
      cmd_if.cmd_dir    = d;
      cmd_if.cmd_steps  = STEPS_W'(s);
      cmd_if.cmd_period = PER_W'(p);
      abort   = ab;
      enable  = en;
      ARESETN = rn;
      model_update(cyc, v, d, s, p, ab, en, rn);
   endtask

   task automatic drive_idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic issue(input bit d, input int s, input int p, output int c);
      drive(1'b1, d, s, p, 1'b0, 1'b1, 1'b1);
      c = cyc;
   endtask

   task automatic clear_logs();
      rise_q.delete();
      done_q.delete();
      hi_cnt = 0;
      busy_seen = 1'b0;
   endtask

   function automatic int qat(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -999;
   endfunction

   initial begin
      int c;
      ARESETN = 1'b0; enable = 1'b1; abort = 1'b0;
      cmd_if.cmd_valid = 1'b0; cmd_if.cmd_dir = 1'b0;
      cmd_if.cmd_steps = '0;   cmd_if.cmd_period = '0;
      model_reset();
      rst_prev_low = 1'b1;
      m_c = 0; m_start = 0; m_n = 0; m_eff = 1; m_issued = 0; m_end = 0; m_dir = 1'b0;

      repeat (3) drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
      #1;
      check("rst_cmd_ready", 64'(cmd_if.cmd_ready), 64'd0);
      drive_idle(1);
      chk_en = 1'b1;
      #1;
      check("rst_step_out",   64'(step_out),   64'd0);
      check("rst_position",   64'(position),   64'd0);
      check("rst_busy",       64'(busy),       64'd0);
      check("rst_steps_left", 64'(steps_left), 64'd0);
      check("rst_cmd_ready",  64'(cmd_if.cmd_ready), 64'd1);

      // 1: forward from reset direction -> DIR setup first
      clear_logs();
      issue(1'b1, 3, 5, c);
      drive_idle(25);
      check("t1_rises",      64'(rise_q.size()), 64'd3);
      check("t1_first_rise", 64'(qat(rise_q, 0) - c), 64'd5);
      check("t1_spacing_a",  64'(qat(rise_q, 1) - qat(rise_q, 0)), 64'd5);
      check("t1_spacing_b",  64'(qat(rise_q, 2) - qat(rise_q, 1)), 64'd5);
      check("t1_hi_cycles",  64'(hi_cnt), 64'd6);
      check("t1_position",   64'(position), 64'd3);
      check("t1_done_at",    64'(qat(done_q, 0) - qat(rise_q, 2)), 64'd5);
      check("t1_busy",       64'(busy), 64'd0);

      // 2: same direction -> no setup
      clear_logs();
      issue(1'b1, 2, 5, c);
      drive_idle(15);
      check("t2_first_rise", 64'(qat(rise_q, 0) - c), 64'd1);
      check("t2_rises",      64'(rise_q.size()), 64'd2);
      check("t2_position",   64'(position), 64'd5);

      // 3: reverse with too-short period -> clamped to 3
      clear_logs();
      issue(1'b0, 4, 1, c);
      drive_idle(25);
      check("t3_first_rise", 64'(qat(rise_q, 0) - c), 64'd5);
      check("t3_spacing",    64'(qat(rise_q, 3) - qat(rise_q, 2)), 64'd3);
      check("t3_rises",      64'(rise_q.size()), 64'd4);
      check("t3_position",   64'(position), 64'd1);

      // 4: zero-step command
      clear_logs();
      issue(1'b0, 0, 7, c);
      drive_idle(5);
      check("t4_done_at",  64'(qat(done_q, 0) - c), 64'd1);
      check("t4_dones",    64'(done_q.size()), 64'd1);
      check("t4_busy_seen", 64'(busy_seen), 64'd0);
      check("t4_hi_cycles", 64'(hi_cnt), 64'd0);
      check("t4_position",  64'(position), 64'd1);

      // 5: abort on first cycle of the second high phase
      clear_logs();
      issue(1'b0, 10, 5, c);
      drive_idle(5);
      drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1);
      drive_idle(10);
      check("t5_rises",      64'(rise_q.size()), 64'd2);
      check("t5_hi_cycles",  64'(hi_cnt), 64'd4);
      check("t5_aborted",    64'(aborted), 64'd1);
      check("t5_steps_left", 64'(steps_left), 64'd8);
      check("t5_done_at",    64'(qat(done_q, 0) - c), 64'd8);
      check("t5_position",   64'(position), 64'hFFFF_FFFF);

      // 6: reset in the middle of a high phase
      clear_logs();
      issue(1'b0, 5, 5, c);
      drive_idle(1);
      drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
      #1;
      check("t6_step_out",  64'(step_out), 64'd0);
      check("t6_position",  64'(position), 64'd0);
      check("t6_cmd_ready", 64'(cmd_if.cmd_ready), 64'd0);
      check("t6_aborted",   64'(aborted), 64'd0);
      drive_idle(3);

      // randomized run
      for (int i = 0; i < 1500; i++) begin
         drive($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 6)), int'($urandom_range(0, 9)),
               $urandom_range(0, 40) == 0, $urandom_range(0, 40) != 0,
               $urandom_range(0, 300) != 0);
      end
      drive_idle(40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
